serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/double_half_adder.sv | 26 ++
 rtl/serial_adder.sv | 162 ++++++++++++++++
 tb/tb_serial_adder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    // Controller states of the serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the adder is meant to be built with
    localparam int MAX_WIDTH = 64;

    // Bit counter width: wide enough to hold WIDTH-1 with one bit of headroom
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/double_half_adder.sv
// One-bit full adder composed of two half adders; the bit-slice datapath
// of the serial adder.
module double_half_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic half_sum;
    logic half_carry_ab;
    logic half_carry_pc;

    // First half adder combines the operand bits
    assign half_sum      = a_i ^ b_i;
    assign half_carry_ab = a_i & b_i;

    // Second half adder folds in the incoming carry
    assign s_o           = half_sum ^ c_i;
    assign half_carry_pc = half_sum & c_i;

    // Either half adder may generate the carry-out; never both at once
    assign c_o           = half_carry_ab | half_carry_pc;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, with valid/ready
// handshakes on both the operand and the result side.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow
// output ovf_o.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_shift;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;

    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last_bit;

    // The full adder always looks at the current LSBs and the carry flop
    double_half_adder u_bit_slice (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    assign accept   = valid_i && (state_q == IDLE);
    assign last_bit = (cnt_q == LAST_CNT);

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
    generate
        if (WIDTH == 1) begin : g_shift_single
            assign s_shift = fa_s;
        end else begin : g_shift_multi
            assign s_shift = {fa_s, s_q[WIDTH-1:1]};
        end
    endgenerate

    // Controller state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; result acceptance and new requests never share a cycle
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand shift registers, sum register, carry flop and bit counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        s_q     <= '0;
                        carry_q <= c_i;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    s_q     <= s_shift;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CNT_ONE;
                end
                default: begin
                    a_q     <= a_q;
                    b_q     <= b_q;
                    s_q     <= s_q;
                    carry_q <= carry_q;
                    cnt_q   <= cnt_q;
                end
            endcase
        end
    end

    assign sum_o = s_q;
    assign c_o   = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_carry_q;

    // Remember the carry going into the MSB; overflow is it differing from the carry out
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            msb_carry_q <= 1'b0;
        end else if (accept) begin
            msb_carry_q <= 1'b0;
        end else if ((state_q == RUN) && last_bit) begin
            msb_carry_q <= carry_q;
        end
    end

    assign ovf_o = msb_carry_q ^ carry_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard queue filled by the
// stimulus, drained by a monitor on each result handshake. Also exercises
// a WIDTH=1 instance exhaustively. Define SERIAL_ADDER_OVF_EN to check ovf_o.
module tb_serial_adder;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             ovf;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             c_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             c_o;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_o;
    logic             ovf_w1;
`endif

    logic             valid_w1_i;
    logic             ready_w1_o;
    logic [0:0]       a_w1;
    logic [0:0]       b_w1;
    logic             c_w1_i;
    logic             valid_w1_o;
    logic             ready_w1_i;
    logic [0:0]       sum_w1;
    logic             c_w1_o;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk_i = ~clk_i;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .c_i     (c_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sum_o   (sum_o),
        .c_o     (c_o)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o   (ovf_o)
`endif
    );

    serial_adder #(.WIDTH(1)) dut_w1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_w1_i),
        .ready_o (ready_w1_o),
        .a_i     (a_w1),
        .b_i     (b_w1),
        .c_i     (c_w1_i),
        .valid_o (valid_w1_o),
        .ready_i (ready_w1_i),
        .sum_o   (sum_w1),
        .c_o     (c_w1_o)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf_o   (ovf_w1)
`endif
    );

    // One comparison: count it, report it if it differs
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request, wait for it to be accepted, optionally score it
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, input logic [WIDTH-1:0] exp_sum,
                                 input logic exp_c, input logic exp_ovf, input bit push);
        int n = 0;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!ready_o) checkOutput("ready_timeout", 64'(ready_o), 1);
        a_i     = a;
        b_i     = b;
        c_i     = c;
        valid_i = 1'b1;
        @(posedge clk_i);
        if (push) exp_q.push_back('{sum: exp_sum, c: exp_c, ovf: exp_ovf});
        #1;
        valid_i = 1'b0;
    endtask

    // Count cycles after acceptance until the result shows up (bounded)
    task automatic waitValid(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!valid_o && cycles < 100);
        if (!valid_o) checkOutput("valid_timeout", 64'(valid_o), 1);
    endtask

    // Monitor: every result handshake is compared with the oldest expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_result", 64'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_sum", 64'(sum_o), 64'(e.sum));
                checkOutput("sb_carry", 64'(c_o), 64'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
                checkOutput("sb_ovf", 64'(ovf_o), 64'(e.ovf));
`endif
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   cyc;
        logic saw_valid;
        logic [2:0] v;
        logic [1:0] t;

        rst_ni     = 1'b0;
        valid_i    = 1'b0;
        a_i        = '0;
        b_i        = '0;
        c_i        = 1'b0;
        ready_i    = 1'b1;
        valid_w1_i = 1'b0;
        a_w1       = '0;
        b_w1       = '0;
        c_w1_i     = 1'b0;
        ready_w1_i = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_ready", 64'(ready_o), 1);
        checkOutput("rst_valid", 64'(valid_o), 0);
        checkOutput("rst_sum", 64'(sum_o), 0);
        checkOutput("rst_carry", 64'(c_o), 0);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("rst_ovf", 64'(ovf_o), 0);
`endif
        rst_ni = 1'b1;
        tick();

        // Basic add with latency and return-to-idle checks
        applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
        checkOutput("ready_in_run", 64'(ready_o), 0);
        waitValid(cyc);
        checkOutput("latency_basic", 64'(cyc), 64'(WIDTH));
        tick();
        checkOutput("ready_after_done", 64'(ready_o), 1);
        checkOutput("valid_after_done", 64'(valid_o), 0);

        // Carry chain
        applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        waitValid(cyc);
        tick();
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        waitValid(cyc);
        tick();

        // Backpressure plus ignored requests during RUN and DONE
        ready_i = 1'b0;
        applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b1);
        tick();
        a_i     = 8'hAA;
        b_i     = 8'h55;
        c_i     = 1'b0;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        waitValid(cyc);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 64'(valid_o), 1);
            checkOutput("bp_sum_hold", 64'(sum_o), 64'h47);
            checkOutput("bp_carry_hold", 64'(c_o), 0);
            checkOutput("bp_ready", 64'(ready_o), 0);
            if (i == 1) valid_i = 1'b1;
            if (i == 2) valid_i = 1'b0;
            tick();
        end
        ready_i = 1'b1;
        tick();
        checkOutput("bp_idle_ready", 64'(ready_o), 1);
        checkOutput("bp_idle_valid", 64'(valid_o), 0);
        tick();
        tick();
        checkOutput("bp_no_spurious_start", 64'(ready_o), 1);

        // Asynchronous reset in the middle of RUN
        applyStimulus(8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_ready", 64'(ready_o), 1);
        checkOutput("arst_valid", 64'(valid_o), 0);
        checkOutput("arst_sum", 64'(sum_o), 0);
        checkOutput("arst_carry", 64'(c_o), 0);
        tick();
        tick();
        tick();
        rst_ni = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 2 * WIDTH + 4; i++) begin
            if (valid_o) saw_valid = 1'b1;
            tick();
        end
        checkOutput("no_valid_after_abort", 64'(saw_valid), 0);
        applyStimulus(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0, 1'b1);
        waitValid(cyc);
        checkOutput("latency_after_reset", 64'(cyc), 64'(WIDTH));
        tick();

        // Signed overflow vectors (sum and carry checked in every build)
        applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        waitValid(cyc);
        tick();
        applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        waitValid(cyc);
        tick();
        applyStimulus(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
        waitValid(cyc);
        tick();

        // WIDTH=1 instance: all eight input combinations
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            v = 3'(i);
            t = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
            while (!ready_w1_o && n < 20) begin
                tick();
                n++;
            end
            if (!ready_w1_o) checkOutput("w1_ready_timeout", 64'(ready_w1_o), 1);
            a_w1       = v[0];
            b_w1       = v[1];
            c_w1_i     = v[2];
            valid_w1_i = 1'b1;
            tick();
            valid_w1_i = 1'b0;
            tick();
            checkOutput("w1_valid", 64'(valid_w1_o), 1);
            checkOutput("w1_sum", 64'(sum_w1), 64'(t[0]));
            checkOutput("w1_carry", 64'(c_w1_o), 64'(t[1]));
            tick();
        end

        checkOutput("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
